// File: rtl/bless_pkg.sv
// Shared definitions for the BLESS deflection router: default widths, port indices,
// default flit layout, and the priority / XY routing helpers.
package bless_pkg;

  localparam int PKTID_W_DEF   = 6;
  localparam int FLITID_W_DEF  = 2;
  localparam int TIME_W_DEF    = 8;
  localparam int COORD_W_DEF   = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int INJ_DEPTH_DEF = 4;

  typedef logic [2:0] port_t;

  localparam port_t P_W     = 3'd0;
  localparam port_t P_E     = 3'd1;
  localparam port_t P_S     = 3'd2;
  localparam port_t P_N     = 3'd3;
  localparam port_t P_LOCAL = 3'd4;
  localparam int    NUM_PORTS = 5;

  typedef struct packed {
    logic                    valid;
    logic [PKTID_W_DEF-1:0]  pktid;
    logic [FLITID_W_DEF-1:0] flitid;
    logic [TIME_W_DEF-1:0]   ts;
    logic [COORD_W_DEF-1:0]  dst_x;
    logic [COORD_W_DEF-1:0]  dst_y;
    logic [DATA_W_DEF-1:0]   data;
  } flit_t;

  localparam int FLIT_W_DEF = $bits(flit_t);

  // True when candidate a has priority over candidate b (older, then lower pktid, then lower port).
  function automatic logic older(input logic [31:0] t_a, input logic [31:0] p_a, input port_t i_a,
                                 input logic [31:0] t_b, input logic [31:0] p_b, input port_t i_b);
    if (t_a != t_b) return t_a < t_b;
    if (p_a != p_b) return p_a < p_b;
    return i_a < i_b;
  endfunction

  function automatic port_t xy_route(input logic [31:0] dst_x, input logic [31:0] dst_y,
                                     input logic [31:0] cur_x, input logic [31:0] cur_y);
    if (dst_x > cur_x) return P_E;
    if (dst_x < cur_x) return P_W;
    if (dst_y > cur_y) return P_N;
    if (dst_y < cur_y) return P_S;
    return P_LOCAL;
  endfunction

  function automatic port_t defl_order(input int k);
    case (k)
      0:       return P_N;
      1:       return P_E;
      2:       return P_S;
      default: return P_W;
    endcase
  endfunction

endpackage

// File: rtl/bless_inj_fifo.sv
// Injection FIFO: power-of-two circular buffer tracked by read pointer plus count.
// The head is read straight from the storage registers, so a push is visible one cycle later.
module bless_inj_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             ready_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] wr_ptr;
  logic             push, pop;

  assign ready_o = count_q < (PTR_W+1)'(DEPTH);
  assign empty_o = (count_q == '0);
  assign push    = push_i && ready_o;
  assign pop     = pop_i && !empty_o;
  assign wr_ptr  = rd_ptr_q + count_q[PTR_W-1:0];
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/bless_router_param.sv
// Parametrised BLESS deflection router: oldest-first allocation of four network flits plus
// one injected flit. Define BLESS_DEFLECT_STATS_EN to build the saturating deflection counter.
module bless_router_param
  import bless_pkg::*;
#(
  parameter int PKTID_W   = PKTID_W_DEF,
  parameter int FLITID_W  = FLITID_W_DEF,
  parameter int TIME_W    = TIME_W_DEF,
  parameter int COORD_W   = COORD_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int INJ_DEPTH = INJ_DEPTH_DEF,
  localparam int FLIT_W   = 1 + PKTID_W + FLITID_W + TIME_W + 2*COORD_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input  logic [FLIT_W-1:0]  din_w,
  input  logic [FLIT_W-1:0]  din_e,
  input  logic [FLIT_W-1:0]  din_s,
  input  logic [FLIT_W-1:0]  din_n,
  output logic [FLIT_W-1:0]  dout_w,
  output logic [FLIT_W-1:0]  dout_e,
  output logic [FLIT_W-1:0]  dout_s,
  output logic [FLIT_W-1:0]  dout_n,
  input  logic [FLIT_W-1:0]  inj_flit,
  input  logic               inj_valid,
  output logic               inj_ready,
  output logic [FLIT_W-1:0]  ej_flit,
  output logic [15:0]        deflect_cnt
);

  localparam int DY_LSB = DATA_W;
  localparam int DX_LSB = DY_LSB + COORD_W;
  localparam int T_LSB  = DX_LSB + COORD_W;
  localparam int P_LSB  = T_LSB + TIME_W + FLITID_W;
  localparam int V_BIT  = FLIT_W - 1;

  logic [FLIT_W-2:0] head_data;
  logic              fifo_empty;
  logic              inj_perm;
  logic              unused_inj_valid_bit;

  logic [FLIT_W-1:0] cand   [NUM_PORTS];
  logic              cand_v [NUM_PORTS];
  port_t             pref   [NUM_PORTS];
  logic [2:0]        rank   [NUM_PORTS];
  port_t             grant  [NUM_PORTS];
  logic [NUM_PORTS-1:0] busy;
  logic              found;
  logic [2:0]        net_cnt;
  logic              any_local;

  logic [FLIT_W-1:0] out_d [NUM_PORTS];
  logic [FLIT_W-1:0] out_q [NUM_PORTS];

  assign unused_inj_valid_bit = inj_flit[V_BIT];

  bless_inj_fifo #(
    .WIDTH (FLIT_W-1),
    .DEPTH (INJ_DEPTH)
  ) u_inj_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inj_valid),
    .data_i  (inj_flit[FLIT_W-2:0]),
    .pop_i   (inj_perm),
    .head_o  (head_data),
    .empty_o (fifo_empty),
    .ready_o (inj_ready)
  );

  always_comb begin
    cand[P_W]     = din_w;
    cand[P_E]     = din_e;
    cand[P_S]     = din_s;
    cand[P_N]     = din_n;
    cand[P_LOCAL] = {1'b1, head_data};
    net_cnt   = '0;
    any_local = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pref[i] = xy_route(32'(cand[i][DX_LSB +: COORD_W]), 32'(cand[i][DY_LSB +: COORD_W]),
                         32'(cur_x), 32'(cur_y));
    end
    for (int i = 0; i < 4; i++) begin
      cand_v[i] = cand[i][V_BIT];
      if (cand_v[i]) begin
        net_cnt = net_cnt + 3'd1;
        if (pref[i] == P_LOCAL) any_local = 1'b1;
      end
    end
    // An ejection frees one network port, so injection fits unless four flits all need the mesh.
    inj_perm = !fifo_empty && ((net_cnt - 3'(any_local)) < 3'd4);
    cand_v[P_LOCAL] = inj_perm;
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      rank[i] = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (j != i && cand_v[j] &&
            older(32'(cand[j][T_LSB +: TIME_W]), 32'(cand[j][P_LSB +: PKTID_W]), port_t'(j),
                  32'(cand[i][T_LSB +: TIME_W]), 32'(cand[i][P_LSB +: PKTID_W]), port_t'(i)))
          rank[i] = rank[i] + 3'd1;
      end
    end
  end

  // Grant in rank order; a blocked flit falls back to the first free mesh port N, E, S, W.
  always_comb begin
    busy  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) grant[i] = P_LOCAL;
    for (int r = 0; r < NUM_PORTS; r++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (cand_v[i] && rank[i] == 3'(r)) begin
          if (!busy[pref[i]]) begin
            grant[i] = pref[i];
          end else begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
              if (!found && !busy[defl_order(k)]) begin
                grant[i] = defl_order(k);
                found    = 1'b1;
              end
            end
          end
          busy[grant[i]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) out_d[p] = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cand_v[i]) out_d[grant[i]] = cand[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) out_q[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) out_q[p] <= out_d[p];
    end
  end

  assign dout_w  = out_q[P_W];
  assign dout_e  = out_q[P_E];
  assign dout_s  = out_q[P_S];
  assign dout_n  = out_q[P_N];
  assign ej_flit = out_q[P_LOCAL];

`ifdef BLESS_DEFLECT_STATS_EN
  logic [2:0]  defl_num;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    defl_num = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cand_v[i] && grant[i] != pref[i]) defl_num = defl_num + 3'd1;
    end
    cnt_sum = {1'b0, cnt_q} + 17'(defl_num);
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign deflect_cnt = cnt_q;
`else
  assign deflect_cnt = 16'h0;
`endif

endmodule

// File: doc/bless_router_param.md
# bless_router_param

Parametrised bufferless deflection (BLESS) mesh router, successor to the fixed-width `topBLESS`. Each cycle it routes up to four network flits (W, E, S, N) plus one locally injected flit. Allocation is oldest-first: the smallest TIME value has highest priority. Losers are deflected to any free port. The block ejects at most one flit per cycle to the local node, and local injection is buffered behind a valid/ready FIFO. It sits at every mesh node between four neighbour links and the node's network interface.

## Interface
- `PKTID_W`, 6, packet-id field width
- `FLITID_W`, 2, flit-id field width
- `TIME_W`, 8, injection-timestamp field width; smaller value means older
- `COORD_W`, 4, width of each X/Y coordinate
- `DATA_W`, 32, payload width
- `INJ_DEPTH`, 4, injection FIFO depth; must be a power of two, ≥2
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `cur_x`, `cur_y`  in  COORD_W each  this router's coordinates; static after reset
- `din_w`, `din_e`, `din_s`, `din_n`  in  FLIT_W each  network inputs; FLIT_W = 1+PKTID_W+FLITID_W+TIME_W+2·COORD_W+DATA_W; layout {valid, pktid, flitid, time, dst_x, dst_y, data}
- `dout_w`, `dout_e`, `dout_s`, `dout_n`  out  FLIT_W each  network outputs, registered
- `inj_flit`  in  FLIT_W  local injection flit; its valid bit is ignored
- `inj_valid`  in  1  injection request
- `inj_ready`  out  1  FIFO not full
- `ej_flit`  out  FLIT_W  ejected flit; its valid bit marks ejection, registered
- `deflect_cnt`  out  16  deflection counter (see Configuration)

## Operation
- **Preferred port**, dimension-ordered XY:
  - dst_x > cur_x → E; dst_x < cur_x → W.
  - Otherwise dst_y > cur_y → N; dst_y < cur_y → S.
  - Otherwise → Local.
- **Candidates:** valid network inputs, plus the FIFO head when injection is permitted.
- **Injection permitted** when the FIFO is non-empty and (valid network inputs − local-bound ejection, 0 or 1) < 4. A free output is therefore guaranteed, and no flit is ever dropped.
- **Priority order:**
  1. Lower TIME wins.
  2. On a TIME tie, lower pktid wins.
  3. Then the fixed order W, E, S, N, Injected.
- **Allocation:** candidates are granted sequentially in priority order.
  - A local-bound flit takes Local if it is free; otherwise it is deflected.
  - A non-local flit takes its preferred port if free.
  - Otherwise it takes the first free network port in order N, E, S, W. This is a deflection.
- **Ejection:** only the highest-priority local-bound flit is ejected. Other local-bound flits are deflected to network ports.
- **Injection FIFO:**
  - Push on `inj_valid && inj_ready`; pop when the head is granted.
  - Push and pop in the same cycle leave the count unchanged.
  - `inj_ready` = count < INJ_DEPTH. It is combinational from the count register.
- Flit contents other than the valid bit pass through unmodified.

## Timing
- Input to output latency is 1 cycle. Inputs are sampled at edge k; the allocation appears on `dout_*` and `ej_flit` after edge k.
- The earliest injection is the cycle after the push. The FIFO head is registered, with no FIFO fall-through.
- **Reset:**
  - All `dout_*` = 0, `ej_flit` = 0, FIFO empty, `inj_ready` = 1, `deflect_cnt` = 0.
  - Reset mid-operation drops the flits in the output registers and flushes the FIFO contents.
- **FIFO full:** `inj_ready` = 0. `inj_valid` is then ignored, and no push occurs even if a pop happens that same cycle.
- **All four network inputs valid, none local-bound:** injection is stalled. The FIFO head is held and `inj_ready` is unaffected except by fullness.
- **Five candidates with one local-bound:** ejection frees a slot, so the injected flit can still be placed.

## Configuration
- Macro: `BLESS_DEFLECT_STATS_EN`.
- **Defined:**
  - `deflect_cnt` counts the deflected flits per cycle, 0–4 added per edge.
  - It saturates at 16'hFFFF and clears on reset.
  - It is registered, so the count reflects the allocations of the previous edge.
- **Undefined:** `deflect_cnt` is tied to 0 and no counter logic is synthesised.

## Structure
- **`bless_pkg`:**
  - Default widths.
  - Port index constants: W=0, E=1, S=2, N=3, LOCAL=4.
  - The flit struct/field offsets.
  - The `older(a,b)` priority function and the XY route function.
- **Sub-module `bless_inj_fifo`:** INJ_DEPTH-entry circular buffer with a pointer plus count, push/pop, a registered head, and the `inj_ready` output.
- The router core (candidate sort, sequential allocation, output registers, counter) stays in `bless_router_param`.

## Test plan
All scenarios use router (1,1) and default widths.

1. **No conflict:**
   - Stimulus: W→dst(2,1) t=15, E→dst(0,1) t=14, S→dst(1,2) t=13, N→dst(1,0) t=12.
   - Required response, next cycle: dout_e=W flit, dout_w=E flit, dout_n=S flit, dout_s=N flit; deflect_cnt=0.
2. **Three flits contend for E:**
   - Stimulus: W, S, N inputs, all dst(2,1), with t=10/11/12.
   - Required response: t=10 on E; t=11 deflected to N; t=12 deflected to S; deflect_cnt=2 one edge later.
3. **Two local-bound flits:**
   - Stimulus: dst(1,1) with t=5 (E) and t=9 (S).
   - Required response: ej_flit = t=5 flit; t=9 flit deflected to N.
4. **Injection blocked then granted:**
   - Stimulus: FIFO holds one flit t=1 while four non-local inputs are valid.
   - Required response: no injection. The next cycle, with the inputs idle, the flit t=1 leaves on its preferred port.
5. **FIFO full:**
   - Stimulus: push 4 flits while all inputs are saturated.
   - Required response: inj_ready=0 after the 4th push. A 5th `inj_valid` is ignored, and FIFO order is preserved on drain.
6. **Reset mid-traffic:**
   - Stimulus: assert reset for 1 cycle with FIFO count=3.
   - Required response: all outputs 0, inj_ready=1, no stale flit emerges afterwards.
